// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - program load, run, HALT drain and status controller for proc
// Optional breakpoint support is compiled in when PROC_RUN_CTRL_BKPT_EN is defined.
module proc_run_ctrl #(
    parameter int                 DATA_W       = 16,
    parameter int                 ADDR_W       = 7,
    parameter logic [DATA_W-1:0]  HALT_OPCODE  = 'h3c00,
    parameter logic [DATA_W-1:0]  HALT_MASK    = 'hffff,
    parameter int                 DRAIN_CYCLES = 3,
    parameter int                 CNT_W        = 32,
    parameter int                 MAX_CYCLES   = 64000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_req,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                load_last,
    input  logic                go,
    input  logic                clr,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    output logic                proc_start,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                ram_read_en,
    input  logic [DATA_W-1:0]   instr,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [ADDR_W-1:0]   halt_pc,
    output logic [ADDR_W:0]     words_loaded,
    output logic [CNT_W-1:0]    cycle_count
`ifdef PROC_RUN_CTRL_BKPT_EN
    ,
    input  logic                bkpt_en,
    input  logic [ADDR_W-1:0]   bkpt_addr,
    output logic                bkpt_hit
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_TIMEOUT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DATA_W-1:0] HALT_CMP    = HALT_OPCODE & HALT_MASK;
    localparam int                DRAIN_LAST  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int                DCNT_W      = (DRAIN_LAST > 0) ? $clog2(DRAIN_LAST + 1) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_END   = DCNT_W'(DRAIN_LAST);

`ifdef PROC_RUN_CTRL_BKPT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_BKPT  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   halt_pc_q, halt_pc_d;
    logic                timeout_q, timeout_d;
    logic [DCNT_W-1:0]   drain_q, drain_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                halt_seen;
    logic [CNT_W-1:0]    cnt_inc;
`ifdef PROC_RUN_CTRL_BKPT_EN
    logic                skip_q, skip_d;
    logic                bkpt_fire;
`endif

    assign proc_start   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign timeout      = timeout_q;
    assign halt_pc      = halt_pc_q;
    assign words_loaded = words_q;
    assign cycle_count  = cnt_q;
`ifdef PROC_RUN_CTRL_BKPT_EN
    assign bkpt_hit     = (state_q == S_BKPT);
`endif

    // instr belongs to the fetch issued one cycle earlier, so qualify it with the registered strobe/pc
    assign halt_seen = rd_q && ((instr & HALT_MASK) == HALT_CMP);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PROC_RUN_CTRL_BKPT_EN
    assign bkpt_fire = rd_q && bkpt_en && (pc_q == bkpt_addr) && !skip_q;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        cnt_d      = cnt_q;
        halt_pc_d  = halt_pc_q;
        timeout_d  = timeout_q;
        drain_d    = drain_q;
        rd_d       = ram_read_en && proc_start;
        pc_d       = pc;
        load_ready = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
`ifdef PROC_RUN_CTRL_BKPT_EN
        skip_d     = skip_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    words_d = '0;
                end else if (go) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    halt_pc_d = '0;
                    timeout_d = 1'b0;
`ifdef PROC_RUN_CTRL_BKPT_EN
                    skip_d    = 1'b0;
`endif
                end
            end

            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = addr_q;
                    ram_din  = load_data;
                    words_d  = words_q + (ADDR_W+1)'(1);
                    // the top address ends the load so the counter never wraps onto word 0
                    if (load_last || (addr_q == ADDR_MAX)) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_inc;
`ifdef PROC_RUN_CTRL_BKPT_EN
                if (rd_q && (pc_q != bkpt_addr)) begin
                    skip_d = 1'b0;
                end
`endif
                if (halt_seen) begin
                    halt_pc_d = pc_q;
                    drain_d   = '0;
                    state_d   = S_DRAIN;
`ifdef PROC_RUN_CTRL_BKPT_EN
                end else if (bkpt_fire) begin
                    skip_d  = 1'b1;
                    state_d = S_BKPT;
`endif
                end else if (cnt_q == CNT_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end

            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (drain_q == DRAIN_END) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DCNT_W'(1);
                end
            end

            S_DONE: begin
                if (clr) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b0;
                end
            end

`ifdef PROC_RUN_CTRL_BKPT_EN
            S_BKPT: begin
                if (go) begin
                    state_d = S_RUN;
                end else if (clr) begin
                    state_d = S_DONE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            cnt_q     <= '0;
            halt_pc_q <= '0;
            timeout_q <= 1'b0;
            drain_q   <= '0;
            rd_q      <= 1'b0;
            pc_q      <= '0;
`ifdef PROC_RUN_CTRL_BKPT_EN
            skip_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            cnt_q     <= cnt_d;
            halt_pc_q <= halt_pc_d;
            timeout_q <= timeout_d;
            drain_q   <= drain_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
`ifdef PROC_RUN_CTRL_BKPT_EN
            skip_q    <= skip_d;
`endif
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - directed vector bench for proc_run_ctrl
module tb_proc_run_ctrl;

    localparam logic [15:0] HALT = 16'h3c00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [15:0] load_data = '0;
    logic        go = 1'b0, clr = 1'b0;
    logic        load_ready, ram_we, proc_start, busy, done, timeout;
    logic [6:0]  ram_addr, halt_pc;
    logic [15:0] ram_din;
    logic [6:0]  pc = '0;
    logic        ram_read_en = 1'b0;
    logic [15:0] instr = '0;
    logic [7:0]  words_loaded;
    logic [31:0] cycle_count;
    logic        bkpt_hit;
`ifdef PROC_RUN_CTRL_BKPT_EN
    logic        bkpt_en = 1'b0;
    logic [6:0]  bkpt_addr = '0;
`else
    assign bkpt_hit = 1'b0;
`endif

    always #5 clk = ~clk;

    proc_run_ctrl #(.MAX_CYCLES(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_req(load_req), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .go(go), .clr(clr),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .proc_start(proc_start), .pc(pc), .ram_read_en(ram_read_en), .instr(instr),
        .busy(busy), .done(done), .timeout(timeout), .halt_pc(halt_pc),
        .words_loaded(words_loaded), .cycle_count(cycle_count)
`ifdef PROC_RUN_CTRL_BKPT_EN
        , .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .bkpt_hit(bkpt_hit)
`endif
    );

    // program RAM model fed by the controller's write port
    logic [15:0] mem [128];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        lreq, go, clr, lv, ll;
        logic [15:0] ld;
        logic        e_rdy, e_we;
        logic [6:0]  e_addr;
        logic        e_busy, e_done;
        logic [7:0]  e_words;
    } vec_t;

    vec_t        vt [13];
    logic [15:0] img [130];

    task automatic pulse_load_req();
        @(negedge clk); load_req = 1'b1;
        @(posedge clk); #1; load_req = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    task automatic do_load(input int n_drive, input int last_idx, input int n_exp, input string name);
        int base;
        int bad;
        base = wr_cnt;
        bad = 0;
        pulse_load_req();
        for (int i = 0; i < n_drive; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = (i == last_idx);
            #1;
            if (i < n_exp) begin
                if (ram_we !== 1'b1 || ram_addr !== 7'(i) || ram_din !== img[i]) bad++;
            end else if (ram_we !== 1'b0) begin
                bad++;
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk({name, "_wr_seq"}, 64'(bad), 64'd0);
        chk({name, "_wr_cnt"}, 64'(wr_cnt - base), 64'(n_exp));
        chk({name, "_status"}, {words_loaded, load_ready, busy}, {8'(n_exp), 1'b0, 1'b0});
    endtask

    // fetch model: one fetch per proc_start cycle, data returned the following cycle
    int fetch_pc, prev_pc, post;
    bit prev_fetch, saw_halt;

    task automatic step();
        if (saw_halt && proc_start) post++;
        instr = prev_fetch ? mem[prev_pc[6:0]] : 16'h0;
        if (prev_fetch && instr == HALT) saw_halt = 1'b1;
        if (proc_start) begin
            ram_read_en = 1'b1;
            pc          = fetch_pc[6:0];
            prev_fetch  = 1'b1;
            prev_pc     = fetch_pc;
            fetch_pc++;
        end else begin
            ram_read_en = 1'b0;
            prev_fetch  = 1'b0;
        end
    endtask

    task automatic run(input bit fresh, input int budget, output bit ok);
        if (fresh) begin
            fetch_pc = 0; prev_fetch = 1'b0; saw_halt = 1'b0; post = 0;
        end
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            step();
            #1;
            if (done || bkpt_hit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        //            lreq go clr lv ll  ld        rdy we addr busy done words
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd0};
        vt[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'habcd, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd0};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd0};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h1111, 1'b1,1'b1,7'd0,1'b1,1'b0,8'd0};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h9999, 1'b1,1'b0,7'd0,1'b1,1'b0,8'd1};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h2222, 1'b1,1'b1,7'd1,1'b1,1'b0,8'd1};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,16'h3333, 1'b1,1'b1,7'd2,1'b1,1'b0,8'd2};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h4444, 1'b1,1'b1,7'd3,1'b1,1'b0,8'd3};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h5555, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd4};
        vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd4};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,7'd0,1'b1,1'b0,8'd0};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h7777, 1'b1,1'b1,7'd0,1'b1,1'b0,8'd0};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,7'd0,1'b0,1'b0,8'd1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state",
            {load_ready, ram_we, ram_addr, ram_din, proc_start, busy, done, timeout,
             halt_pc, words_loaded, cycle_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            load_req   = vt[i].lreq;
            go         = vt[i].go;
            clr        = vt[i].clr;
            load_valid = vt[i].lv;
            load_last  = vt[i].ll;
            load_data  = vt[i].ld;
            #1;
            chk($sformatf("vec%0d", i),
                {load_ready, ram_we, ram_addr, ram_din, busy, done, proc_start, words_loaded},
                {vt[i].e_rdy, vt[i].e_we, vt[i].e_addr, (vt[i].e_we ? vt[i].ld : 16'h0),
                 vt[i].e_busy, vt[i].e_done, 1'b0, vt[i].e_words});
        end
        load_req = 1'b0; go = 1'b0; clr = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        chk("mem_load4", {mem[0], mem[1], mem[2], mem[3]}, 64'h7777_2222_3333_4444);

        // full-depth load without load_last: stops at 128 words, no wrap
        for (int i = 0; i < 130; i++) img[i] = 16'(i * 3 + 1);
        do_load(130, -1, 128, "load128");
        chk("load128_ends", {mem[0], mem[127]}, {16'h0001, 16'(127 * 3 + 1)});

        // HALT at pc=5
        for (int i = 0; i < 5; i++) img[i] = 16'(i + 1);
        img[5] = HALT;
        do_load(6, 5, 6, "load_halt5");
        pulse_go();
        run(1'b1, 200, ok);
        chk("halt5_reached", 64'(ok), 64'd1);
        chk("halt5_status", {done, timeout, proc_start, busy}, 4'b1000);
        chk("halt5_pc_cnt", {halt_pc, cycle_count}, {7'd5, 32'd10});
        chk("halt5_drain", 64'(post), 64'd3);
        pulse_clr();
        chk("clr_keeps", {done, timeout, halt_pc, cycle_count, words_loaded},
            {1'b0, 1'b0, 7'd5, 32'd10, 8'd6});

        // no HALT: timeout at MAX_CYCLES=20
        img[5] = 16'h0006;
        do_load(6, 5, 6, "load_nohalt");
        pulse_go();
        run(1'b1, 200, ok);
        chk("timeout_reached", 64'(ok), 64'd1);
        chk("timeout_status", {done, timeout, proc_start, halt_pc, cycle_count},
            {1'b1, 1'b1, 1'b0, 7'd0, 32'd20});
        pulse_clr();
        chk("timeout_clr", {done, timeout, busy, cycle_count}, {1'b0, 1'b0, 1'b0, 32'd20});

        // HALT qualified in the same cycle as the timeout limit
        for (int i = 0; i < 18; i++) img[i] = 16'(i + 1);
        img[18] = HALT;
        do_load(19, 18, 19, "load_halt18");
        pulse_go();
        run(1'b1, 200, ok);
        chk("halt_vs_timeout", {done, timeout, halt_pc, cycle_count},
            {1'b1, 1'b0, 7'd18, 32'd23});
        chk("halt18_drain", 64'(post), 64'd3);
        pulse_clr();

        // asynchronous reset mid-run, then a clean rerun
        for (int i = 0; i < 5; i++) img[i] = 16'(i + 1);
        img[5] = HALT;
        do_load(6, 5, 6, "load_halt5b");
        pulse_go();
        run(1'b1, 3, ok);
        chk("pre_reset_running", {proc_start, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset",
            {proc_start, busy, done, timeout, halt_pc, words_loaded, cycle_count,
             ram_we, load_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ram_read_en = 1'b0;
        pulse_go();
        run(1'b1, 200, ok);
        chk("rerun_after_reset", {done, timeout, halt_pc, cycle_count},
            {1'b1, 1'b0, 7'd5, 32'd10});
        chk("rerun_drain", 64'(post), 64'd3);
        pulse_clr();

`ifdef PROC_RUN_CTRL_BKPT_EN
        bkpt_en   = 1'b1;
        bkpt_addr = 7'd2;
        pulse_go();
        run(1'b1, 200, ok);
        chk("bkpt_reached", 64'(ok), 64'd1);
        chk("bkpt_status", {bkpt_hit, proc_start, busy, done, cycle_count},
            {1'b1, 1'b0, 1'b1, 1'b0, 32'd4});
        pulse_go();
        chk("bkpt_resume", {bkpt_hit, proc_start}, 2'b01);
        run(1'b0, 200, ok);
        chk("bkpt_halt", {done, bkpt_hit, timeout, halt_pc, cycle_count},
            {1'b1, 1'b0, 1'b0, 7'd5, 32'd10});
        bkpt_en = 1'b0;
        pulse_clr();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Parametrised run controller between the program RAM and `proc`.
- Loads a program image into the RAM through a valid/ready stream, then asserts `start` to the processor.
- Watches fetched instructions for a configurable HALT encoding, drains a fixed number of cycles, and reports done, timeout, halt PC and cycle count.
- Replaces ad-hoc start/halt sequencing with synthesizable logic, so any `ram_rw_WxD` / `proc` width and depth pairing runs unattended.

Parameters:
- DATA_W, 16, instruction/data word width
- ADDR_W, 7, program RAM address width (depth = 2**ADDR_W)
- HALT_OPCODE, 16'h3c00, HALT encoding compared against fetched word
- HALT_MASK, 16'hffff, bits of fetched word that take part in the HALT compare
- DRAIN_CYCLES, 3, cycles held in DRAIN after HALT is seen (lets writeback/stores retire)
- CNT_W, 32, cycle counter width
- MAX_CYCLES, 64000000, RUN cycle limit before timeout

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  pulse in IDLE: begin program load at address 0
- load_valid  in  1  load word valid
- load_ready  out  1  controller accepts a load word
- load_data  in  DATA_W  load word
- load_last  in  1  marks final load word
- go  in  1  pulse in IDLE: start processor run
- clr  in  1  pulse in DONE: clear status, return to IDLE
- ram_we  out  1  program RAM write enable
- ram_addr  out  ADDR_W  program RAM write address
- ram_din  out  DATA_W  program RAM write data
- proc_start  out  1  drives proc start
- pc  in  ADDR_W  proc fetch address
- ram_read_en  in  1  proc fetch strobe
- instr  in  DATA_W  RAM dout; valid one cycle after ram_read_en
- busy  out  1  state is not IDLE or DONE
- done  out  1  run finished
- timeout  out  1  run ended by MAX_CYCLES
- halt_pc  out  ADDR_W  address of the HALT fetch
- words_loaded  out  ADDR_W+1  words written by the last load
- cycle_count  out  CNT_W  RUN+DRAIN cycles

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is asynchronous. Asserting it mid-operation drops proc_start and ram_we immediately.
- States are IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - load_req → LOAD; clears words_loaded and sets the address counter to 0.
  - go → RUN; clears cycle_count, halt_pc and timeout.
  - load_req and go in the same cycle: load_req wins.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid&&load_ready: ram_we=1, ram_addr=counter, ram_din=load_data. ram_we/ram_addr/ram_din are combinational from the handshake, so the write lands in the same cycle. Counter and words_loaded then increment.
  - The accepted word is the last one if load_last=1 or counter==2**ADDR_W-1; then → IDLE next cycle.
  - Counter never wraps. A load with exactly 2**ADDR_W words gives words_loaded=2**ADDR_W.
- RUN:
  - proc_start=1; cycle_count increments every cycle, saturating at all-ones.
  - A registered copy of ram_read_en and pc qualifies instr.
  - When the qualified instr satisfies (instr&HALT_MASK)==(HALT_OPCODE&HALT_MASK): capture halt_pc from the registered pc, → DRAIN.
  - When cycle_count==MAX_CYCLES-1 with no HALT: timeout=1, → DONE.
  - HALT and timeout in the same cycle: HALT wins, timeout stays 0.
- DRAIN:
  - proc_start stays 1; cycle_count keeps counting.
  - After exactly DRAIN_CYCLES cycles → DONE.
  - DRAIN_CYCLES=0: DRAIN lasts one cycle.
- DONE:
  - proc_start=0, done=1; status held until clr → IDLE.
  - clr clears done and timeout. halt_pc, cycle_count and words_loaded are kept until the next go/load_req.
- Pulses that do not match the current state (go/load_req outside IDLE, clr outside DONE, load_valid outside LOAD) are ignored.

Optional Feature:
- Macro: PROC_RUN_CTRL_BKPT_EN.
- When defined:
  - Adds inputs bkpt_en (1) and bkpt_addr (ADDR_W), plus output bkpt_hit (1).
  - In RUN, a qualified fetch with bkpt_en=1 and registered pc==bkpt_addr enters BKPT: proc_start=0, bkpt_hit=1, cycle_count frozen.
  - go in BKPT → RUN and clears bkpt_hit. That breakpoint does not re-fire until pc differs from bkpt_addr at a later qualified fetch.
  - clr in BKPT → DONE.
  - HALT and breakpoint at the same fetch: HALT wins.
- When undefined: none of these ports or the BKPT state exist.

Test Plan:
- Load 4 words (last on word 4), each 0x1111·n → ram writes at addresses 0..3, words_loaded=4, state back to IDLE, load_ready=0.
- Load with load_last never asserted, ADDR_W=7 → exactly 128 writes, words_loaded=128, no wrap to address 0.
- go; HALT fetched at pc=5 → halt_pc=5, proc_start held for exactly 3 DRAIN cycles then 0, done=1, timeout=0.
- MAX_CYCLES=20, program with no HALT → done=1, timeout=1, cycle_count=20.
- Assert rst_n=0 during RUN → proc_start and all status outputs 0 without waiting for a clk edge. After release, a fresh go runs normally.
- With PROC_RUN_CTRL_BKPT_EN, bkpt_addr=2 → bkpt_hit=1, proc_start=0; go resumes and run still halts at pc=5 with done=1.
